// File: rtl/sa_arith_pkg.sv
// Shared arithmetic-unit definitions: control-state encoding, Booth recoding and
// counter sizing used by the sequential multiplier and divider.
package sa_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_e;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_e;

    // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], Q_-1}.
    function automatic booth_op_e booth_decode(input logic q0, input logic qm1);
        booth_op_e op;
        case ({q0, qm1})
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

    // Counter width able to hold the iteration count WIDTH.
    function automatic int sa_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: conditional add/sub of Mreg into A,
// then arithmetic shift right of {A, Q, Q_-1} by one bit.
module booth_step
    import sa_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic             qm1,
    input  logic [WIDTH:0]   mreg,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             qm1_next
);

    booth_op_e        op_s;
    logic [WIDTH:0]   sum_s;

    // Add/sub selected by the Booth pair, followed by the sign-preserving shift.
    always_comb begin
        op_s  = booth_decode(q[0], qm1);
        sum_s = a;
        case (op_s)
            BOOTH_ADD: sum_s = a + mreg;
            BOOTH_SUB: sum_s = a - mreg;
            default:   sum_s = a;
        endcase
        a_next   = {sum_s[WIDTH], sum_s[WIDTH:1]};
        q_next   = {sum_s[0], q[WIDTH-1:1]};
        qm1_next = q[0];
    end

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential signed radix-2 Booth multiplier with start/done handshake.
// Optional BOOTH_ZERO_SKIP_EN: zero operands bypass the iterations (done one cycle after accept).
module booth_multiplier_seq
    import sa_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int                CNT_W    = sa_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WIDTH);

    sa_state_e              state_r;
    sa_state_e              state_next_s;
    logic [WIDTH:0]         a_r;
    logic [WIDTH-1:0]       q_r;
    logic                   qm1_r;
    logic [WIDTH:0]         mreg_r;
    logic [CNT_W-1:0]       count_r;
    logic [2*WIDTH-1:0]     product_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   zero_pend_r;

    logic [WIDTH:0]         a_step_s;
    logic [WIDTH-1:0]       q_step_s;
    logic                   qm1_step_s;
    logic                   ready_s;
    logic                   accept_s;
    logic                   zero_op_s;
    logic                   last_step_s;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a        (a_r),
        .q        (q_r),
        .qm1      (qm1_r),
        .mreg     (mreg_r),
        .a_next   (a_step_s),
        .q_next   (q_step_s),
        .qm1_next (qm1_step_s)
    );

    // Handshake qualification; a pending zero-skip blocks a second accept.
    always_comb begin
        if ((state_r == IDLE || state_r == DONE) && !zero_pend_r) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        accept_s    = start && ready_s;
        last_step_s = (state_r == RUN) && (count_r == CNT_ONE);
`ifdef BOOTH_ZERO_SKIP_EN
        zero_op_s = (multiplicand == {WIDTH{1'b0}}) || (multiplier == {WIDTH{1'b0}});
`else
        zero_op_s = 1'b0;
`endif
    end

    // Next-state logic; a zero-skip waits one cycle in IDLE before DONE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (zero_pend_r) begin
                    state_next_s = DONE;
                end else if (accept_s) begin
                    state_next_s = zero_op_s ? IDLE : RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (count_r == CNT_ONE) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, Booth iteration, product capture and registered status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r         <= {(WIDTH+1){1'b0}};
            q_r         <= {WIDTH{1'b0}};
            qm1_r       <= 1'b0;
            mreg_r      <= {(WIDTH+1){1'b0}};
            count_r     <= {CNT_W{1'b0}};
            product_r   <= {(2*WIDTH){1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            zero_pend_r <= 1'b0;
        end else begin
            busy_r      <= (state_next_s == RUN);
            done_r      <= (state_next_s == DONE);
            zero_pend_r <= accept_s && zero_op_s;
            if (accept_s && !zero_op_s) begin
                a_r     <= {(WIDTH+1){1'b0}};
                q_r     <= multiplier;
                qm1_r   <= 1'b0;
                mreg_r  <= {multiplicand[WIDTH-1], multiplicand};
                count_r <= CNT_INIT;
            end else if (state_r == RUN) begin
                a_r     <= a_step_s;
                q_r     <= q_step_s;
                qm1_r   <= qm1_step_s;
                count_r <= count_r - CNT_ONE;
            end else begin
                count_r <= count_r;
            end
            // Product only moves on the edge that enters DONE.
            if (last_step_s) begin
                product_r <= {a_step_s[WIDTH-1:0], q_step_s};
            end else if (zero_pend_r) begin
                product_r <= {(2*WIDTH){1'b0}};
            end else begin
                product_r <= product_r;
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule
